// File: rtl/apv_seq_pkg.sv
// Shared definitions for the APV readout sequencer: word tags, FSM states and
// the output word packers.
package apv_seq_pkg;

  localparam logic [3:0] TAG_HDR  = 4'hC;
  localparam logic [3:0] TAG_DATA = 4'h0;
  localparam logic [3:0] TAG_TRL  = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SEL   = 3'd2,
    S_MEAN  = 3'd3,
    S_HDR   = 3'd4,
    S_READ  = 3'd5,
    S_TRAIL = 3'd6
  } seq_state_e;

  function automatic logic [31:0] pack_hdr(input logic [4:0] ch, input logic [11:0] mean);
    return {TAG_HDR, ch, 11'b0, mean};
  endfunction

  function automatic logic [31:0] pack_data(input logic [4:0] ch, input logic [12:0] data);
    return {TAG_DATA, ch, 10'b0, data};
  endfunction

  function automatic logic [31:0] pack_trl(input logic [7:0] missed, input logic [19:0] evt_cnt);
    return {TAG_TRL, missed, evt_cnt};
  endfunction

endpackage

// File: rtl/seq_skid2.sv
// Two-entry output buffer. Handshake: a word transfers on a clock edge where
// out_valid_o and out_ready_i are both high; push_i is honoured only while in_ready_o.
module seq_skid2 (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        push_i,
  input  logic [31:0] data_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [1:0]  slots_free_o
);

  logic [31:0] head_q, tail_q;
  logic [1:0]  count_q;
  logic        pop, push;

  assign pop  = (count_q != 2'd0) && out_ready_i;
  assign push = push_i && (count_q != 2'd2);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= data_i;
          else                 tail_q <= data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) head_q <= data_i;
          else begin
            head_q <= tail_q;
            tail_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o   = (count_q != 2'd2);
  assign out_data_o   = head_q;
  assign out_valid_o  = (count_q != 2'd0);
  // Slots that will be free once this cycle's pop has happened.
  assign slots_free_o = 2'd2 - count_q + {1'b0, pop};

endmodule

// File: rtl/apv_readout_sequencer.sv
// Event builder: waits for all enabled APV channels, then drains each one's
// mean and data FIFOs in ascending order into a tagged 32-bit stream.
module apv_readout_sequencer
  import apv_seq_pkg::*;
#(
  parameter int N_CH        = 16,
  parameter int EVENT_WORDS = 130,
  parameter int TMO_W       = 16
) (
  input  logic               CLK,
  input  logic               RSTb,
  input  logic               ENABLE,
  input  logic [N_CH-1:0]    CH_MASK,
  input  logic [TMO_W-1:0]   TIMEOUT,
  input  logic [N_CH-1:0]    CH_EVENT_READY,
  input  logic [N_CH-1:0]    CH_FIFO_EMPTY,
  input  logic [13*N_CH-1:0] CH_DATA,
  input  logic [12*N_CH-1:0] CH_MEAN,
  output logic [N_CH-1:0]    CH_FIFO_RD,
  output logic [N_CH-1:0]    CH_RD_NEXT_MEAN,
  output logic [31:0]        OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               EVENT_DONE,
  output logic               BUSY,
  output logic               TIMEOUT_ERR
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WL_W = $clog2(EVENT_WORDS + 1);
  localparam logic [WL_W-1:0] WL_INIT = WL_W'(EVENT_WORDS);

  seq_state_e       state_q, state_d;
  logic [N_CH-1:0]  active_q, active_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [WL_W-1:0]  words_left_q, words_left_d;
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]       missed_q, missed_d;
  logic [19:0]      evt_cnt_q;
  logic             rd_pend_q, err_q;

  logic [N_CH-1:0]  ready_m;
  logic             all_ready, tmo_take, sel_found, rd_ok, mean_ok;
  logic [CH_W-1:0]  sel_idx;
  logic [12:0]      data_arr [N_CH];
  logic [11:0]      mean_arr [N_CH];
  logic [1:0]       slots_free;
  logic             skid_in_ready, push;
  logic [31:0]      push_data;

  function automatic logic [7:0] sat_count(input logic [N_CH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N_CH; i++) if (v[i]) n++;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      data_arr[i] = CH_DATA[13*i +: 13];
      mean_arr[i] = CH_MEAN[12*i +: 12];
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (active_q[i]) sel_idx = CH_W'(i);
  end

  assign sel_found = |active_q;
  assign ready_m   = CH_EVENT_READY & CH_MASK;
  assign all_ready = (ready_m == CH_MASK);
  assign tmo_take  = (state_q == S_WAIT) && ENABLE && !all_ready && (TIMEOUT != '0) &&
                     (wait_cnt_q == TIMEOUT) && (|ready_m);
  // A read is only issued if the word it returns next cycle is sure to fit.
  assign rd_ok     = (state_q == S_READ) && !CH_FIFO_EMPTY[ch_q] && (words_left_q != '0) &&
                     (slots_free > {1'b0, rd_pend_q});
  assign mean_ok   = (slots_free != 2'd0);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q      <= S_IDLE;
      active_q     <= '0;
      ch_q         <= '0;
      words_left_q <= '0;
      wait_cnt_q   <= '0;
      missed_q     <= '0;
      evt_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      ch_q         <= ch_d;
      words_left_q <= words_left_d;
      wait_cnt_q   <= wait_cnt_d;
      missed_q     <= missed_d;
      rd_pend_q    <= rd_ok;
      if (EVENT_DONE) evt_cnt_q <= evt_cnt_q + 20'd1;
      if (!ENABLE)       err_q <= 1'b0;
      else if (tmo_take) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    ch_d         = ch_q;
    words_left_d = words_left_q;
    wait_cnt_d   = wait_cnt_q;
    missed_d     = missed_q;
    case (state_q)
      S_IDLE: begin
        wait_cnt_d = '0;
        if (ENABLE && (CH_MASK != '0)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!ENABLE) state_d = S_IDLE;
        else if (all_ready || tmo_take) begin
          state_d  = S_SEL;
          active_d = ready_m;
          missed_d = sat_count(CH_MASK & ~ready_m);
        end else if (!((TIMEOUT != '0) && (wait_cnt_q == TIMEOUT))) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_SEL: begin
        if (sel_found) begin
          state_d           = S_MEAN;
          ch_d              = sel_idx;
          active_d[sel_idx] = 1'b0;
          words_left_d      = WL_INIT;
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_MEAN:  if (mean_ok) state_d = S_HDR;
      S_HDR:   state_d = S_READ;
      S_READ: begin
        if (rd_ok) words_left_d = words_left_q - 1'b1;
        if ((words_left_q == '0) && rd_pend_q) state_d = S_SEL;
      end
      S_TRAIL: if (skid_in_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    CH_FIFO_RD      = '0;
    CH_RD_NEXT_MEAN = '0;
    push            = 1'b0;
    push_data       = '0;
    EVENT_DONE      = 1'b0;
    case (state_q)
      S_MEAN: CH_RD_NEXT_MEAN[ch_q] = mean_ok;
      S_HDR: begin
        push      = 1'b1;
        push_data = pack_hdr(5'(ch_q), mean_arr[ch_q]);
      end
      S_READ: begin
        CH_FIFO_RD[ch_q] = rd_ok;
        push             = rd_pend_q;
        push_data        = pack_data(5'(ch_q), data_arr[ch_q]);
      end
      S_TRAIL: begin
        push       = skid_in_ready;
        push_data  = pack_trl(missed_q, evt_cnt_q);
        EVENT_DONE = skid_in_ready;
      end
      default: ;
    endcase
  end

  assign BUSY        = (state_q != S_IDLE);
  assign TIMEOUT_ERR = err_q;

  seq_skid2 u_skid (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .push_i       (push),
    .data_i       (push_data),
    .in_ready_o   (skid_in_ready),
    .out_data_o   (OUT_DATA),
    .out_valid_o  (OUT_VALID),
    .out_ready_i  (OUT_READY),
    .slots_free_o (slots_free)
  );

endmodule

// File: tb/tb_apv_readout_sequencer.sv
// Bench for apv_readout_sequencer: behavioural channel FIFOs, an event-level
// expected-word queue and directed scenarios with randomized data.
module tb_apv_readout_sequencer;

  localparam int N  = 4;
  localparam int EW = 130;

  logic            CLK = 1'b0;
  logic            RSTb = 1'b0;
  logic            ENABLE = 1'b0;
  logic [N-1:0]    CH_MASK = '0;
  logic [15:0]     TIMEOUT = '0;
  logic [N-1:0]    CH_EVENT_READY = '0;
  logic [N-1:0]    CH_FIFO_EMPTY = '1;
  logic [13*N-1:0] CH_DATA = '0;
  logic [12*N-1:0] CH_MEAN = '0;
  logic [N-1:0]    CH_FIFO_RD, CH_RD_NEXT_MEAN;
  logic [31:0]     OUT_DATA;
  logic            OUT_VALID, EVENT_DONE, BUSY, TIMEOUT_ERR;
  logic            OUT_READY = 1'b0;

  apv_readout_sequencer #(.N_CH(N), .EVENT_WORDS(EW), .TMO_W(16)) dut (
    .CLK(CLK), .RSTb(RSTb), .ENABLE(ENABLE), .CH_MASK(CH_MASK), .TIMEOUT(TIMEOUT),
    .CH_EVENT_READY(CH_EVENT_READY), .CH_FIFO_EMPTY(CH_FIFO_EMPTY),
    .CH_DATA(CH_DATA), .CH_MEAN(CH_MEAN), .CH_FIFO_RD(CH_FIFO_RD),
    .CH_RD_NEXT_MEAN(CH_RD_NEXT_MEAN), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .EVENT_DONE(EVENT_DONE), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // channel FIFO contents and per-event reference records
  logic [12:0] dq[N][$];
  logic [11:0] mq[N][$];
  logic [12:0] ev_data[N][$];
  logic [11:0] ev_mean[N];
  int          loaded[N];
  logic [31:0] exp_q[$];
  logic [19:0] exp_evt = '0;

  int          checks = 0;
  int          failures = 0;
  int          rd_cnt[N];
  int          rd_base[N];
  int          done_cnt = 0;
  int          word_cnt = 0;
  int          word_base = 0;
  logic [31:0] last_trl = '0;
  logic        rdy_rand = 1'b0;

  initial for (int i = 0; i < N; i++) rd_cnt[i] = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // non-show-ahead FIFO behaviour and downstream ready
  always @(posedge CLK) begin
    OUT_READY <= rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < N; i++) begin
      if (CH_FIFO_RD[i] && dq[i].size() > 0) begin
        CH_DATA[13*i +: 13] <= dq[i].pop_front();
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
      if (CH_RD_NEXT_MEAN[i] && mq[i].size() > 0) CH_MEAN[12*i +: 12] <= mq[i].pop_front();
      CH_FIFO_EMPTY[i]  <= (dq[i].size() == 0);
      CH_EVENT_READY[i] <= (mq[i].size() != 0);
    end
  end

  // scoreboard and request monitor
  always @(negedge CLK) begin
    if (RSTb) begin
      if (OUT_VALID && OUT_READY) begin
        word_cnt++;
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("out_word", OUT_DATA, exp_q.pop_front());
        if (OUT_DATA[31:28] == 4'hE) last_trl = OUT_DATA;
      end
      if (EVENT_DONE) done_cnt++;
      if (CH_FIFO_RD != '0) chk("rd_onehot", 32'($onehot(CH_FIFO_RD)), 32'd1);
      if (CH_RD_NEXT_MEAN != '0) chk("mean_onehot", 32'($onehot(CH_RD_NEXT_MEAN)), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (CH_FIFO_RD[i]) chk("rd_not_empty", 32'(dq[i].size() != 0), 32'd1);
        if (CH_RD_NEXT_MEAN[i]) chk("mean_not_empty", 32'(mq[i].size() != 0), 32'd1);
      end
    end
  end

  // driver tasks
  task automatic load_event(input int ch, input int n_now);
    ev_data[ch].delete();
    ev_mean[ch] = 12'($urandom);
    mq[ch].push_back(ev_mean[ch]);
    for (int k = 0; k < EW; k++) ev_data[ch].push_back(13'($urandom));
    for (int k = 0; k < n_now; k++) dq[ch].push_back(ev_data[ch][k]);
    loaded[ch] = n_now;
  endtask

  task automatic top_up(input int ch);
    for (int k = loaded[ch]; k < EW; k++) dq[ch].push_back(ev_data[ch][k]);
    loaded[ch] = EW;
  endtask

  // Reference: header + data of every captured channel in index order, then trailer.
  task automatic expect_event(input logic [N-1:0] act, input int missed);
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        exp_q.push_back({4'hC, 5'(i), 11'b0, ev_mean[i]});
        for (int k = 0; k < EW; k++) exp_q.push_back({4'h0, 5'(i), 10'b0, ev_data[i][k]});
      end
    end
    exp_q.push_back({4'hE, 8'(missed), exp_evt});
    exp_evt = exp_evt + 20'd1;
  endtask

  task automatic mark_counts();
    for (int i = 0; i < N; i++) rd_base[i] = rd_cnt[i];
    word_base = word_cnt;
  endtask

  function automatic int rdn(input int ch);
    return rd_cnt[ch] - rd_base[ch];
  endfunction

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while ((done_cnt < target || exp_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("done_count", 32'(done_cnt), 32'(target));
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_reads(input int ch, input int cnt, input int budget);
    int n;
    n = 0;
    while (rdn(ch) < cnt && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("reads_reached", 32'(rdn(ch) >= cnt), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(OUT_VALID), 32'd0);
    chk({tag, "_data"}, OUT_DATA, 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(EVENT_DONE), 32'd0);
    chk({tag, "_err"}, 32'(TIMEOUT_ERR), 32'd0);
    chk({tag, "_rd"}, 32'(CH_FIFO_RD), 32'd0);
    chk({tag, "_mrd"}, 32'(CH_RD_NEXT_MEAN), 32'd0);
  endtask

  initial begin
    RSTb = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RSTb = 1'b1;
    @(negedge CLK);

    // all four channels ready, downstream always ready
    mark_counts();
    for (int i = 0; i < N; i++) load_event(i, EW);
    expect_event(4'b1111, 0);
    CH_MASK = 4'b1111;
    TIMEOUT = 16'd0;
    ENABLE  = 1'b1;
    wait_done(1, 3000);
    chk("t1_trailer", last_trl, 32'hE000_0000);
    chk("t1_words", 32'(word_cnt - word_base), 32'd525);
    chk("t1_no_err", 32'(TIMEOUT_ERR), 32'd0);
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t1_idle", 32'(BUSY), 32'd0);

    // random downstream backpressure, second event
    rdy_rand = 1'b1;
    mark_counts();
    for (int i = 0; i < N; i++) load_event(i, EW);
    expect_event(4'b1111, 0);
    ENABLE = 1'b1;
    wait_done(2, 6000);
    chk("t2_trailer", last_trl, 32'hE000_0001);
    chk("t2_words", 32'(word_cnt - word_base), 32'd525);
    rdy_rand = 1'b0;
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);

    // timeout with only ch0 of mask 0101 ready
    mark_counts();
    CH_MASK = 4'b0101;
    TIMEOUT = 16'd100;
    load_event(0, EW);
    expect_event(4'b0001, 1);
    ENABLE = 1'b1;
    repeat (95) @(negedge CLK);
    chk("t3_err_early", 32'(TIMEOUT_ERR), 32'd0);
    chk("t3_busy_wait", 32'(BUSY), 32'd1);
    wait_done(3, 3000);
    chk("t3_err_set", 32'(TIMEOUT_ERR), 32'd1);
    chk("t3_trailer", last_trl, 32'hE010_0002);
    chk("t3_words", 32'(word_cnt - word_base), 32'd132);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t3_err_clear", 32'(TIMEOUT_ERR), 32'd0);
    TIMEOUT = 16'd0;

    // ch1 data FIFO runs dry after 60 words, refilled 20 cycles later
    mark_counts();
    CH_MASK = 4'b1111;
    for (int i = 0; i < N; i++) load_event(i, (i == 1) ? 60 : EW);
    expect_event(4'b1111, 0);
    ENABLE = 1'b1;
    wait_reads(1, 60, 2000);
    repeat (20) @(negedge CLK);
    chk("t4_ch1_stalled", 32'(rdn(1)), 32'd60);
    chk("t4_busy_stall", 32'(BUSY), 32'd1);
    top_up(1);
    wait_done(4, 3000);
    chk("t4_ch1_total", 32'(rdn(1)), 32'(EW));
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);

    // ENABLE dropped while ch2 is being read: event still completes
    mark_counts();
    for (int i = 0; i < N; i++) load_event(i, EW);
    expect_event(4'b1111, 0);
    ENABLE = 1'b1;
    wait_reads(2, 10, 2000);
    ENABLE = 1'b0;
    wait_done(5, 3000);
    chk("t5_ch3_total", 32'(rdn(3)), 32'(EW));
    repeat (2) @(negedge CLK);
    chk("t5_idle", 32'(BUSY), 32'd0);

    // asynchronous reset in the middle of a channel block
    rdy_rand = 1'b1;
    mark_counts();
    for (int i = 0; i < N; i++) load_event(i, EW);
    expect_event(4'b1111, 0);
    ENABLE = 1'b1;
    wait_reads(1, 30, 3000);
    @(negedge CLK);
    #2;
    RSTb = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    exp_evt = '0;
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    RSTb = 1'b1;
    @(negedge CLK);
    mark_counts();
    for (int i = 0; i < N; i++) load_event(i, EW);
    expect_event(4'b1111, 0);
    ENABLE = 1'b1;
    wait_done(6, 6000);
    chk("t6_trailer", last_trl, 32'hE000_0000);
    chk("t6_words", 32'(word_cnt - word_base), 32'd525);
    rdy_rand = 1'b0;
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
